text_banner_ctrl: RTL and testbench

Sequencer for the on-screen text banners ("PONG", "P1 WINS", score digits). It sits between the VGA pixel counter and the bank of fixed-size glyph renderers. For each pixel it works out which character slot the pixel falls in and drives the shared `start_x`/`start_y` origin for that slot. A frame-driven state machine shows the banner for a fixed time, blinks it, then clears it.

---
 rtl/text_banner_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_text_banner_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/text_banner_ctrl.sv
// text_banner_ctrl: maps each pixel onto a banner character slot and drives the shared
// glyph origin, while a frame-counted FSM shows, blinks and finally clears the banner.
module text_banner_ctrl #(
    parameter int NUM_CHARS     = 4,
    parameter int CHAR_W        = 26,
    parameter int CHAR_H        = 40,
    parameter int CHAR_GAP      = 6,
    parameter int BASE_Y        = 200,
    parameter int SHOW_FRAMES   = 180,
    parameter int BLINK_PERIOD  = 15,
    parameter int BLINK_TOGGLES = 6
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [9:0]  i_x,
    input  logic [9:0]  i_y,
    input  logic        i_frame_tick,
    input  logic        i_start,
    input  logic [2:0]  i_msg_len,
    input  logic [9:0]  i_center_x,
    output logic [31:0] o_start_x,
    output logic [31:0] o_start_y,
    output logic [1:0]  o_slot_idx,
    output logic        o_slot_valid,
    output logic        o_busy,
    output logic        o_done
);
    localparam int PITCH = CHAR_W + CHAR_GAP;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHOW,
        S_BLINK
    } state_t;

    state_t        r_state, w_stateNext;
    logic [15:0]   r_frameCnt, w_frameCntNext;
    logic [7:0]    r_toggleCnt, w_toggleCntNext;
    logic          r_visible, w_visibleNext;
    logic          r_done, w_doneNext;
    logic [9:0]    r_left, w_leftNext;
    logic [2:0]    r_len, w_lenNext;

    logic          w_startOk;
    logic [10:0]   w_span;
    logic [10:0]   w_half;
    logic signed [10:0] w_leftS;
    logic [9:0]    w_leftClamped;

    logic [10:0]          w_slotLo [NUM_CHARS];
    logic [NUM_CHARS-1:0] w_slotHit;
    logic                 w_yIn;
    logic                 w_pixValid;
    logic [1:0]           w_hitIdx;
    logic [10:0]          w_hitX;

    logic [31:0]   r_startX;
    logic [31:0]   r_startY;
    logic [1:0]    r_slotIdx;
    logic          r_slotValid;

    assign w_startOk = i_start && (i_msg_len != 3'd0) &&
                       ({29'd0, i_msg_len} <= 32'(NUM_CHARS));

    // Banner width excludes the trailing gap; a left edge that would fall off screen pins to 0.
    assign w_span        = 11'(i_msg_len) * 11'(PITCH) - 11'(CHAR_GAP);
    assign w_half        = w_span >> 1;
    assign w_leftS       = $signed({1'b0, i_center_x}) - $signed(w_half);
    assign w_leftClamped = w_leftS[10] ? 10'd0 : w_leftS[9:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_frameCnt  <= '0;
            r_toggleCnt <= '0;
            r_visible   <= 1'b0;
            r_done      <= 1'b0;
            r_left      <= '0;
            r_len       <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_frameCnt  <= w_frameCntNext;
            r_toggleCnt <= w_toggleCntNext;
            r_visible   <= w_visibleNext;
            r_done      <= w_doneNext;
            r_left      <= w_leftNext;
            r_len       <= w_lenNext;
        end
    end

    // A valid start overrides any counter expiry in the same cycle and never produces done.
    always_comb begin
        w_stateNext     = r_state;
        w_frameCntNext  = r_frameCnt;
        w_toggleCntNext = r_toggleCnt;
        w_visibleNext   = r_visible;
        w_doneNext      = 1'b0;
        w_leftNext      = r_left;
        w_lenNext       = r_len;
        if (w_startOk) begin
            w_stateNext     = S_SHOW;
            w_frameCntNext  = '0;
            w_toggleCntNext = '0;
            w_visibleNext   = 1'b1;
            w_leftNext      = w_leftClamped;
            w_lenNext       = i_msg_len;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_visibleNext = 1'b0;
                end
                S_SHOW: begin
                    if (i_frame_tick) begin
                        if (r_frameCnt == 16'(SHOW_FRAMES - 1)) begin
                            w_stateNext     = S_BLINK;
                            w_frameCntNext  = '0;
                            w_toggleCntNext = '0;
                        end else begin
                            w_frameCntNext = r_frameCnt + 16'd1;
                        end
                    end
                end
                S_BLINK: begin
                    if (i_frame_tick) begin
                        if (r_frameCnt == 16'(BLINK_PERIOD - 1)) begin
                            w_frameCntNext  = '0;
                            w_visibleNext   = ~r_visible;
                            w_toggleCntNext = r_toggleCnt + 8'd1;
                            if (r_toggleCnt == 8'(BLINK_TOGGLES - 1)) begin
                                w_stateNext     = S_IDLE;
                                w_visibleNext   = 1'b0;
                                w_toggleCntNext = '0;
                                w_doneNext      = 1'b1;
                            end
                        end else begin
                            w_frameCntNext = r_frameCnt + 16'd1;
                        end
                    end
                end
                default: begin
                    w_stateNext   = S_IDLE;
                    w_visibleNext = 1'b0;
                end
            endcase
        end
    end

    // Slot bounds stay 11 bits wide so edges beyond column 1023 can never alias onto x.
    for (genvar k = 0; k < NUM_CHARS; k++) begin : g_slot
        assign w_slotLo[k]  = {1'b0, r_left} + 11'(k * PITCH);
        assign w_slotHit[k] = (3'(k) < r_len) &&
                              ({1'b0, i_x} >= w_slotLo[k]) &&
                              ({1'b0, i_x} < (w_slotLo[k] + 11'(CHAR_W)));
    end

    assign w_yIn = (i_y >= 10'(BASE_Y)) && (i_y < 10'(BASE_Y + CHAR_H));

    always_comb begin
        w_hitIdx = '0;
        w_hitX   = '0;
        for (int k = 0; k < NUM_CHARS; k++) begin
            if (w_slotHit[k]) begin
                w_hitIdx = 2'(k);
                w_hitX   = w_slotLo[k];
            end
        end
    end

    assign w_pixValid = (|w_slotHit) && w_yIn && r_visible;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_startX    <= '0;
            r_startY    <= '0;
            r_slotIdx   <= '0;
            r_slotValid <= 1'b0;
        end else begin
            r_slotValid <= w_pixValid;
            r_startX    <= w_pixValid ? {21'd0, w_hitX} : 32'd0;
            r_startY    <= w_pixValid ? 32'(BASE_Y) : 32'd0;
            r_slotIdx   <= w_pixValid ? w_hitIdx : 2'd0;
        end
    end

    assign o_start_x    = r_startX;
    assign o_start_y    = r_startY;
    assign o_slot_idx   = r_slotIdx;
    assign o_slot_valid = r_slotValid;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = r_done;

endmodule

// File: tb/tb_text_banner_ctrl.sv
// Directed bench for text_banner_ctrl: slot geometry, clamping, show/blink timing,
// restart, invalid starts and start/expiry collision, all against hand-derived values.
module tb_text_banner_ctrl;
    logic        clk;
    logic        rst_n;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        frame_tick;
    logic        start;
    logic [2:0]  msg_len;
    logic [9:0]  center_x;
    logic [31:0] start_x;
    logic [31:0] start_y;
    logic [1:0]  slot_idx;
    logic        slot_valid;
    logic        busy;
    logic        done;

    int checkCnt;
    int passCnt;
    int doneCnt;
    int doneBase;

    text_banner_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_x          (x),
        .i_y          (y),
        .i_frame_tick (frame_tick),
        .i_start      (start),
        .i_msg_len    (msg_len),
        .i_center_x   (center_x),
        .o_start_x    (start_x),
        .o_start_y    (start_y),
        .o_slot_idx   (slot_idx),
        .o_slot_valid (slot_valid),
        .o_busy       (busy),
        .o_done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial doneCnt = 0;
    always @(negedge clk) if (done === 1'b1) doneCnt++;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic resetDut();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
        end
    endtask

    task automatic startBanner(input logic [2:0] len, input logic [9:0] cx);
        @(negedge clk);
        start = 1'b1; msg_len = len; center_x = cx;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pixel(input logic [9:0] px, input logic [9:0] py);
        @(negedge clk);
        x = px; y = py;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checkCnt++; if (slot_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL reset_init: got v=%0b b=%0b d=%0b expected 0 0 0", slot_valid, busy, done); else passCnt++;
        resetDut();
        startBanner(3'd4, 10'd320);
        pixel(10'd259, 10'd200);
        checkCnt++; if (slot_valid !== 1'b1 || busy !== 1'b1) $display("[TB] FAIL reset_preshow: got v=%0b b=%0b expected 1 1", slot_valid, busy); else passCnt++;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkCnt++; if (slot_valid !== 1'b0 || slot_idx !== 2'd0) $display("[TB] FAIL reset_async_slot: got v=%0b idx=%0d expected 0 0", slot_valid, slot_idx); else passCnt++;
        checkCnt++; if (start_x !== 32'd0 || start_y !== 32'd0) $display("[TB] FAIL reset_async_xy: got %0d,%0d expected 0,0", start_x, start_y); else passCnt++;
        checkCnt++; if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL reset_async_busy: got b=%0b d=%0b expected 0 0", busy, done); else passCnt++;
        @(negedge clk) rst_n = 1'b1;
        doneBase = doneCnt;
        tick(300);
        checkCnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_post_busy: got %0b expected 0", busy); else passCnt++;
        checkCnt++; if (doneCnt - doneBase !== 0) $display("[TB] FAIL reset_post_done: got %0d pulses expected 0", doneCnt - doneBase); else passCnt++;
        pixel(10'd259, 10'd200);
        checkCnt++; if (slot_valid !== 1'b0) $display("[TB] FAIL reset_post_pixel: got %0b expected 0", slot_valid); else passCnt++;
    endtask

    task automatic test_geometry();
        resetDut();
        startBanner(3'd4, 10'd320);
        checkCnt++; if (busy !== 1'b1) $display("[TB] FAIL geo_busy: got %0b expected 1", busy); else passCnt++;
        pixel(10'd259, 10'd200);
        checkCnt++; if (slot_valid !== 1'b1 || start_x !== 32'd259 || slot_idx !== 2'd0) $display("[TB] FAIL geo_slot0: got v=%0b x=%0d idx=%0d expected 1 259 0", slot_valid, start_x, slot_idx); else passCnt++;
        checkCnt++; if (start_y !== 32'd200) $display("[TB] FAIL geo_start_y: got %0d expected 200", start_y); else passCnt++;
        pixel(10'd258, 10'd200);
        checkCnt++; if (slot_valid !== 1'b0 || start_x !== 32'd0) $display("[TB] FAIL geo_left_edge: got v=%0b x=%0d expected 0 0", slot_valid, start_x); else passCnt++;
        pixel(10'd285, 10'd200);
        checkCnt++; if (slot_valid !== 1'b0 || start_y !== 32'd0) $display("[TB] FAIL geo_gap: got v=%0b y=%0d expected 0 0", slot_valid, start_y); else passCnt++;
        pixel(10'd291, 10'd239);
        checkCnt++; if (slot_valid !== 1'b1 || start_x !== 32'd291 || slot_idx !== 2'd1) $display("[TB] FAIL geo_slot1: got v=%0b x=%0d idx=%0d expected 1 291 1", slot_valid, start_x, slot_idx); else passCnt++;
        pixel(10'd355, 10'd200);
        checkCnt++; if (slot_valid !== 1'b1 || start_x !== 32'd355 || slot_idx !== 2'd3) $display("[TB] FAIL geo_slot3: got v=%0b x=%0d idx=%0d expected 1 355 3", slot_valid, start_x, slot_idx); else passCnt++;
        pixel(10'd380, 10'd200);
        checkCnt++; if (slot_valid !== 1'b1 || slot_idx !== 2'd3) $display("[TB] FAIL geo_slot3_last: got v=%0b idx=%0d expected 1 3", slot_valid, slot_idx); else passCnt++;
        pixel(10'd381, 10'd200);
        checkCnt++; if (slot_valid !== 1'b0 || slot_idx !== 2'd0) $display("[TB] FAIL geo_right_edge: got v=%0b idx=%0d expected 0 0", slot_valid, slot_idx); else passCnt++;
        pixel(10'd300, 10'd240);
        checkCnt++; if (slot_valid !== 1'b0) $display("[TB] FAIL geo_y_bottom: got %0b expected 0", slot_valid); else passCnt++;
        pixel(10'd300, 10'd199);
        checkCnt++; if (slot_valid !== 1'b0) $display("[TB] FAIL geo_y_top: got %0b expected 0", slot_valid); else passCnt++;
    endtask

    task automatic test_clamp();
        startBanner(3'd4, 10'd10);
        pixel(10'd0, 10'd200);
        checkCnt++; if (slot_valid !== 1'b1 || start_x !== 32'd0 || slot_idx !== 2'd0) $display("[TB] FAIL clamp_slot0: got v=%0b x=%0d idx=%0d expected 1 0 0", slot_valid, start_x, slot_idx); else passCnt++;
        pixel(10'd26, 10'd200);
        checkCnt++; if (slot_valid !== 1'b0) $display("[TB] FAIL clamp_gap: got %0b expected 0", slot_valid); else passCnt++;
        pixel(10'd32, 10'd210);
        checkCnt++; if (slot_valid !== 1'b1 || start_x !== 32'd32 || slot_idx !== 2'd1) $display("[TB] FAIL clamp_slot1: got v=%0b x=%0d idx=%0d expected 1 32 1", slot_valid, start_x, slot_idx); else passCnt++;
        startBanner(3'd1, 10'd320);
        pixel(10'd307, 10'd200);
        checkCnt++; if (slot_valid !== 1'b1 || start_x !== 32'd307) $display("[TB] FAIL len1_slot0: got v=%0b x=%0d expected 1 307", slot_valid, start_x); else passCnt++;
        pixel(10'd339, 10'd200);
        checkCnt++; if (slot_valid !== 1'b0) $display("[TB] FAIL len1_unused_slot: got %0b expected 0", slot_valid); else passCnt++;
    endtask

    task automatic test_sequence();
        resetDut();
        doneBase = doneCnt;
        startBanner(3'd2, 10'd320);
        tick(179);
        pixel(10'd291, 10'd200);
        checkCnt++; if (slot_valid !== 1'b1 || start_x !== 32'd291) $display("[TB] FAIL seq_show_179: got v=%0b x=%0d expected 1 291", slot_valid, start_x); else passCnt++;
        tick(15);
        pixel(10'd291, 10'd200);
        checkCnt++; if (slot_valid !== 1'b1) $display("[TB] FAIL seq_blink_194: got %0b expected 1", slot_valid); else passCnt++;
        tick(1);
        pixel(10'd291, 10'd200);
        checkCnt++; if (slot_valid !== 1'b0 || busy !== 1'b1) $display("[TB] FAIL seq_hidden_195: got v=%0b b=%0b expected 0 1", slot_valid, busy); else passCnt++;
        tick(15);
        pixel(10'd291, 10'd200);
        checkCnt++; if (slot_valid !== 1'b1) $display("[TB] FAIL seq_shown_210: got %0b expected 1", slot_valid); else passCnt++;
        tick(59);
        checkCnt++; if (busy !== 1'b1 || doneCnt - doneBase !== 0) $display("[TB] FAIL seq_269: got b=%0b pulses=%0d expected 1 0", busy, doneCnt - doneBase); else passCnt++;
        @(negedge clk) frame_tick = 1'b1;
        @(posedge clk);
        #1;
        checkCnt++; if (done !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL seq_done: got d=%0b b=%0b expected 1 0", done, busy); else passCnt++;
        @(negedge clk) frame_tick = 1'b0;
        @(posedge clk);
        #1;
        checkCnt++; if (done !== 1'b0) $display("[TB] FAIL seq_done_width: got %0b expected 0", done); else passCnt++;
        pixel(10'd291, 10'd200);
        checkCnt++; if (slot_valid !== 1'b0 || doneCnt - doneBase !== 1) $display("[TB] FAIL seq_cleared: got v=%0b pulses=%0d expected 0 1", slot_valid, doneCnt - doneBase); else passCnt++;
        tick(20);
        checkCnt++; if (busy !== 1'b0 || doneCnt - doneBase !== 1) $display("[TB] FAIL seq_idle_ticks: got b=%0b pulses=%0d expected 0 1", busy, doneCnt - doneBase); else passCnt++;
    endtask

    task automatic test_restart();
        resetDut();
        startBanner(3'd4, 10'd320);
        tick(195);
        pixel(10'd259, 10'd200);
        checkCnt++; if (slot_valid !== 1'b0 || busy !== 1'b1) $display("[TB] FAIL rst_blink_hidden: got v=%0b b=%0b expected 0 1", slot_valid, busy); else passCnt++;
        doneBase = doneCnt;
        startBanner(3'd2, 10'd320);
        pixel(10'd291, 10'd200);
        checkCnt++; if (slot_valid !== 1'b1 || start_x !== 32'd291 || slot_idx !== 2'd0) $display("[TB] FAIL rst_relatch: got v=%0b x=%0d idx=%0d expected 1 291 0", slot_valid, start_x, slot_idx); else passCnt++;
        tick(194);
        pixel(10'd291, 10'd200);
        checkCnt++; if (slot_valid !== 1'b1) $display("[TB] FAIL rst_visible_194: got %0b expected 1", slot_valid); else passCnt++;
        tick(1);
        pixel(10'd291, 10'd200);
        checkCnt++; if (slot_valid !== 1'b0 || busy !== 1'b1) $display("[TB] FAIL rst_hidden_195: got v=%0b b=%0b expected 0 1", slot_valid, busy); else passCnt++;
        checkCnt++; if (doneCnt - doneBase !== 0) $display("[TB] FAIL rst_no_done: got %0d pulses expected 0", doneCnt - doneBase); else passCnt++;
    endtask

    task automatic test_invalid();
        resetDut();
        startBanner(3'd0, 10'd320);
        pixel(10'd259, 10'd200);
        checkCnt++; if (busy !== 1'b0 || slot_valid !== 1'b0) $display("[TB] FAIL inv_len0: got b=%0b v=%0b expected 0 0", busy, slot_valid); else passCnt++;
        startBanner(3'd5, 10'd320);
        pixel(10'd259, 10'd200);
        checkCnt++; if (busy !== 1'b0 || slot_valid !== 1'b0) $display("[TB] FAIL inv_len5: got b=%0b v=%0b expected 0 0", busy, slot_valid); else passCnt++;
    endtask

    task automatic test_back_to_back();
        resetDut();
        startBanner(3'd1, 10'd320);
        tick(269);
        doneBase = doneCnt;
        @(negedge clk);
        frame_tick = 1'b1; start = 1'b1; msg_len = 3'd2; center_x = 10'd320;
        @(posedge clk);
        #1;
        checkCnt++; if (busy !== 1'b1 || done !== 1'b0) $display("[TB] FAIL sim_state: got b=%0b d=%0b expected 1 0", busy, done); else passCnt++;
        @(negedge clk);
        frame_tick = 1'b0; start = 1'b0;
        pixel(10'd291, 10'd200);
        checkCnt++; if (slot_valid !== 1'b1 || start_x !== 32'd291) $display("[TB] FAIL sim_relatch: got v=%0b x=%0d expected 1 291", slot_valid, start_x); else passCnt++;
        tick(15);
        pixel(10'd291, 10'd200);
        checkCnt++; if (slot_valid !== 1'b1 || busy !== 1'b1) $display("[TB] FAIL sim_in_show: got v=%0b b=%0b expected 1 1", slot_valid, busy); else passCnt++;
        checkCnt++; if (doneCnt - doneBase !== 0) $display("[TB] FAIL sim_no_done: got %0d pulses expected 0", doneCnt - doneBase); else passCnt++;
    endtask

    initial begin
        checkCnt = 0; passCnt = 0; doneBase = 0;
        rst_n = 1'b0; x = '0; y = '0; frame_tick = 1'b0;
        start = 1'b0; msg_len = '0; center_x = '0;
        #12;
        test_reset();
        test_geometry();
        test_clamp();
        test_sequence();
        test_restart();
        test_invalid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
